// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, instruction memory,
// branch-resolution logic and decode.
//   imem_req/imem_addr   : fetch request to memory (level-held until ack)
//   imem_ack/imem_data   : one-cycle ack with the instruction word
//   redirect/redirect_pc : one-cycle branch-taken pulse and target
//   stall                : decode cannot accept the presented instruction
//   instr_valid/instr/instr_pc/pc_plus_two : instruction presented to decode
//   halted               : HLT consumed, fetch stopped
// master = fetch sequencer side, slave = environment side.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus_two;
  logic        halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    input  redirect, redirect_pc, stall,
    output instr_valid, instr, instr_pc, pc_plus_two, halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    output redirect, redirect_pc, stall,
    input  instr_valid, instr, instr_pc, pc_plus_two, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the single-issue 16-bit core.
// Owns the fetch PC, issues one outstanding request at a time to a
// variable-latency instruction memory, presents fetched instructions to
// decode with a valid/stall handshake, applies branch redirects and stops
// permanently after a HLT instruction is consumed (only reset exits).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   fs    : fetch_sequencer_if.master (memory, redirect and decode signals)
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  OPCODE_HLT = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  fs
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_OUT   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_started;
  logic [15:0] r_fetch_pc;
  logic [15:0] r_redir_pc_q;
  logic        r_redir_pend;
  logic [15:0] r_instr;
  logic [15:0] r_instr_pc;

  logic [15:0] w_redirect_pc;
  logic        w_req;
  logic        w_take;
  logic        w_is_hlt;

  assign w_redirect_pc = {fs.redirect_pc[15:1], 1'b0};
  // r_started keeps imem_req low until the first edge after reset release.
  assign w_req         = (r_state == ST_FETCH) && r_started;
  assign w_take        = w_req && fs.imem_ack;
  assign w_is_hlt      = (r_instr[15:12] == OPCODE_HLT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FETCH: begin
        if (w_take && !r_redir_pend && !fs.redirect) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        // Redirect wins over HLT; with stall=1 the held instruction is dropped.
        if (fs.redirect)     w_state_nxt = ST_FETCH;
        else if (!fs.stall)  w_state_nxt = w_is_hlt ? ST_HALT : ST_FETCH;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started    <= 1'b0;
      r_fetch_pc   <= {RESET_PC[15:1], 1'b0};
      r_redir_pc_q <= '0;
      r_redir_pend <= 1'b0;
      r_instr      <= '0;
      r_instr_pc   <= '0;
    end else begin
      r_started <= 1'b1;
      unique case (r_state)
        ST_FETCH: begin
          if (w_take) begin
            // The outstanding request completed; a pending or same-cycle
            // redirect discards the returned word and retargets fetch.
            r_redir_pend <= 1'b0;
            if (fs.redirect)       r_fetch_pc <= w_redirect_pc;
            else if (r_redir_pend) r_fetch_pc <= r_redir_pc_q;
            else begin
              r_instr    <= fs.imem_data;
              r_instr_pc <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + 16'd2;
            end
          end else if (fs.redirect) begin
            if (w_req) begin
              // Address must stay stable until the in-flight request acks.
              r_redir_pend <= 1'b1;
              r_redir_pc_q <= w_redirect_pc;
            end else begin
              r_fetch_pc <= w_redirect_pc;
            end
          end
        end
        ST_OUT: begin
          if (fs.redirect) r_fetch_pc <= w_redirect_pc;
        end
        default: ;
      endcase
    end
  end

  assign fs.imem_req    = w_req;
  assign fs.imem_addr   = r_fetch_pc;
  assign fs.instr_valid = (r_state == ST_OUT);
  assign fs.instr       = r_instr;
  assign fs.instr_pc    = r_instr_pc;
  assign fs.pc_plus_two = r_instr_pc + 16'd2;
  assign fs.halted      = (r_state == ST_HALT);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives instruction fetch for the single-issue 16-bit core.
- Owns the fetch PC and issues requests to a variable-latency instruction memory, one request outstanding at a time, over a req/ack handshake.
- Presents each fetched instruction to decode with a valid/stall handshake.
- Applies branch redirects from the branch-resolution logic, and stops fetching permanently once a HLT instruction has been consumed.

Parameters:
- RESET_PC, 16'h0000, fetch address loaded on reset.
- OPCODE_HLT, 4'hF, opcode value in instr[15:12] that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_req  output  1  fetch request, level-held until ack.
- imem_addr  output  16  fetch address; stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse; imem_data is valid in the same cycle.
- imem_data  input  16  instruction word returned by memory.
- redirect  input  1  one-cycle pulse; branch taken, restart fetch at redirect_pc.
- redirect_pc  input  16  branch target; bit 0 ignored (forced 0).
- stall  input  1  decode cannot accept the presented instruction this cycle.
- instr_valid  output  1  instr, instr_pc and pc_plus_two are valid.
- instr  output  16  instruction word held for decode.
- instr_pc  output  16  address of instr.
- pc_plus_two  output  16  instr_pc + 2, modulo 2^16.
- halted  output  1  HLT consumed; fetch stopped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=FETCH, fetch_pc=RESET_PC, redir_pend=0.
  - instr_valid=0, instr=0, instr_pc=0, halted=0.
  - imem_req=0 while rst_n=0. After release, imem_req=1 from the first clock edge.
  - Reset asserted mid-transaction abandons any outstanding request. Memory must tolerate this.
- State FETCH:
  - imem_req=1, imem_addr=fetch_pc, instr_valid=0.
  - On imem_ack with redir_pend=0 and redirect=0: instr<=imem_data, instr_pc<=fetch_pc, fetch_pc<=fetch_pc+2, go to OUT.
  - On imem_ack with redirect=1 or redir_pend=1: discard the data. fetch_pc<=redirect_pc if redirect=1, else redir_pc_q. Clear redir_pend. Stay in FETCH; the next request goes to the new address.
  - Redirect without ack: redir_pend<=1, redir_pc_q<=redirect_pc. imem_addr stays unchanged until ack, since the outstanding request must complete. A later redirect overwrites redir_pc_q.
- State OUT:
  - instr_valid=1, imem_req=0. instr, instr_pc and pc_plus_two are held stable while stall=1.
  - stall=0 means the instruction is consumed this cycle:
    - If instr[15:12]==OPCODE_HLT, go to HALT.
    - Otherwise go to FETCH.
  - redirect=1 in OUT: fetch_pc<=redirect_pc and go to FETCH.
    - If stall=0 in the same cycle, the held instruction counts as consumed.
    - If stall=1, the held instruction is dropped; instr_valid=0 from the next cycle.
    - Redirect takes priority over HLT in the same cycle.
- State HALT:
  - halted=1, imem_req=0, instr_valid=0.
  - redirect and imem_ack are ignored.
  - Only reset exits this state.
- Arithmetic: all PC arithmetic is 16-bit and wraps; 0xFFFE+2=0x0000. Bit 0 of fetch_pc is always 0.
- Throughput: minimum 2 cycles per instruction (ack in the first FETCH cycle, then OUT with stall=0).
- imem_data is ignored when imem_ack=0. An imem_ack arriving outside FETCH is ignored.

Test Plan:
- Reset release; memory acks immediately with 0x1234 -> imem_addr=0x0000 for one cycle; next cycle instr_valid=1, instr=0x1234, instr_pc=0x0000, pc_plus_two=0x0002; then imem_req=1 with imem_addr=0x0002.
- Ack latency 3 cycles on address 0x0002 -> imem_req=1 and imem_addr=0x0002 held for 3 cycles; instr_valid=0 throughout; instr_pc=0x0002 once valid.
- stall=1 for 2 cycles while instr=0x2345 is valid -> outputs unchanged, imem_req=0; on stall=0, the next cycle requests 0x0004.
- redirect to 0x0100 during a wait, then ack with 0xAAAA -> 0xAAAA never presented (instr_valid stays 0); the next request is imem_addr=0x0100.
- redirect to 0x0200 during OUT with stall=1 -> instr_valid=0 next cycle, imem_addr=0x0200; fetch_pc 0xFFFE fetched normally -> next imem_addr=0x0000.
- Fetch 0xF000 consumed (stall=0) -> halted=1, imem_req=0 indefinitely, redirect ignored; rst_n=0 then asserts all reset values immediately, without waiting for a clock edge, and fetch restarts at 0x0000.
